// File: rtl/video_src_switch.sv
// video_src_switch: NUM_SRC-input video source selector for the HDMI output.
// Source changes commit only on the leading vsync edge of the current source
// (or after a timeout), then the output is blanked for BLANK_FRAMES frames of
// the new source. All outputs, including status flags, share one pipeline.
//
// Handshake: there is no valid/ready flow control here. sel is a level that
// may change at any time; the block samples it every cycle and acts on it
// only as the FSM allows (out-of-range indices are ignored).
module video_src_switch #(
    parameter int NUM_SRC      = 4,
    parameter int SEL_W        = 3,
    parameter int COLOR_W      = 8,
    parameter int PIPE_DEPTH   = 2,
    parameter int BLANK_FRAMES = 2,
    parameter bit VS_POL       = 1'b1,
    parameter int TIMEOUT_CYC  = 2000000,
    parameter int TO_W         = 21
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [SEL_W-1:0]               sel,
    input  logic [NUM_SRC*3*COLOR_W-1:0]   src_rgb,
    input  logic [NUM_SRC-1:0]             src_hs,
    input  logic [NUM_SRC-1:0]             src_vs,
    input  logic [NUM_SRC-1:0]             src_de,
    output logic [3*COLOR_W-1:0]           out_rgb,
    output logic                           out_hs,
    output logic                           out_vs,
    output logic                           out_de,
    output logic [SEL_W-1:0]               active_src,
    output logic                           switching,
    output logic                           audio_mute
);

    localparam int RGB_W = 3 * COLOR_W;
    localparam int FC_W  = $clog2(BLANK_FRAMES + 1);
    localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(BLANK_FRAMES - 1);
    localparam logic [SEL_W:0]   NUM_SRC_L  = (SEL_W + 1)'(NUM_SRC);

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_MUTE    = 2'd2
    } state_t;

    typedef struct packed {
        logic [RGB_W-1:0] rgb;
        logic             hs;
        logic             vs;
        logic             de;
        logic [SEL_W-1:0] act;
        logic             sw;
        logic             mute;
    } stage_t;

    localparam stage_t PIPE_RST = '{
        rgb:  '0,
        hs:   1'b0,
        vs:   ~VS_POL,
        de:   1'b0,
        act:  '0,
        sw:   1'b1,
        mute: 1'b1
    };

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  cur_q, cur_d;
    logic [SEL_W-1:0]  tgt_q, tgt_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              vs_hist_q, vs_hist_d;
    stage_t            pipe_q [PIPE_DEPTH];
    stage_t            pipe_d [PIPE_DEPTH];

    logic [RGB_W-1:0]  cur_rgb;
    logic              cur_hs;
    logic              cur_vs;
    logic              cur_de;
    logic              nxt_vs;
    logic              vs_act;
    logic              vs_lead;
    logic              sel_valid;
    logic              to_exp;
    logic              blank;
    logic              de0;

    // Route the current source, and look up the vsync of the next source so the
    // edge history can be reloaded when cur changes.
    always_comb begin
        cur_rgb = '0;
        cur_hs  = 1'b0;
        cur_vs  = ~VS_POL;
        cur_de  = 1'b0;
        nxt_vs  = ~VS_POL;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (cur_q == SEL_W'(k)) begin
                cur_rgb = src_rgb[k*RGB_W +: RGB_W];
                cur_hs  = src_hs[k];
                cur_vs  = src_vs[k];
                cur_de  = src_de[k];
            end
            if (cur_d == SEL_W'(k)) begin
                nxt_vs = src_vs[k];
            end
        end
    end

    assign vs_act    = (cur_vs == VS_POL);
    assign vs_lead   = vs_act && !vs_hist_q;
    assign sel_valid = ({1'b0, sel} < NUM_SRC_L);
    assign to_exp    = (to_cnt_q == TO_MAX);

    // Switch controller: next-state, target, frame and timeout counters.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        tgt_d       = tgt_q;
        frame_cnt_d = frame_cnt_q;
        to_cnt_d    = '0;
        case (state_q)
            ST_LOCKED: begin
                if (sel_valid && (sel != cur_q)) begin
                    tgt_d   = sel;
                    state_d = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                // A valid sel always retargets; the latest request wins even
                // when it arrives together with the committing vsync edge.
                if (sel_valid) begin
                    tgt_d = sel;
                end
                if (sel_valid && (sel == cur_q)) begin
                    state_d = ST_LOCKED;
                end else if (vs_lead || to_exp) begin
                    cur_d       = tgt_d;
                    frame_cnt_d = '0;
                    state_d     = ST_MUTE;
                end else begin
                    to_cnt_d = to_exp ? to_cnt_q : to_cnt_q + TO_W'(1);
                end
            end
            ST_MUTE: begin
                if (sel_valid && (sel != cur_q)) begin
                    tgt_d   = sel;
                    state_d = ST_WAIT_VS;
                end else if (vs_lead) begin
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                    if (frame_cnt_q == FC_LAST) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            default: begin
                state_d = ST_MUTE;
            end
        endcase
        // Reload the history from the new source so the swap itself never
        // looks like a leading edge.
        vs_hist_d = (cur_d != cur_q) ? (nxt_vs == VS_POL) : vs_act;
    end

    // Stage 0 applies the blanking decision; later stages only delay.
    always_comb begin
        blank = (state_q == ST_MUTE);
        de0   = cur_de && !blank;
        pipe_d[0].rgb  = de0 ? cur_rgb : '0;
        pipe_d[0].hs   = cur_hs;
        pipe_d[0].vs   = cur_vs;
        pipe_d[0].de   = de0;
        pipe_d[0].act  = cur_q;
        pipe_d[0].sw   = (state_q != ST_LOCKED);
        pipe_d[0].mute = (state_q != ST_LOCKED);
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // All state and pipeline registers; vsync history starts as "active" so a
    // sync pulse in progress at reset release is not counted as a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_MUTE;
            cur_q       <= '0;
            tgt_q       <= '0;
            frame_cnt_q <= '0;
            to_cnt_q    <= '0;
            vs_hist_q   <= 1'b1;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_q[i] <= PIPE_RST;
            end
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            tgt_q       <= tgt_d;
            frame_cnt_q <= frame_cnt_d;
            to_cnt_q    <= to_cnt_d;
            vs_hist_q   <= vs_hist_d;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign out_rgb    = pipe_q[PIPE_DEPTH-1].rgb;
    assign out_hs     = pipe_q[PIPE_DEPTH-1].hs;
    assign out_vs     = pipe_q[PIPE_DEPTH-1].vs;
    assign out_de     = pipe_q[PIPE_DEPTH-1].de;
    assign active_src = pipe_q[PIPE_DEPTH-1].act;
    assign switching  = pipe_q[PIPE_DEPTH-1].sw;
    assign audio_mute = pipe_q[PIPE_DEPTH-1].mute;

endmodule

// File: doc/video_src_switch.md
Name: video_src_switch

Overview:
- Parametrised N-input video source selector for the HDMI output path. It generalises the fixed two-source mux to NUM_SRC sources with a configurable output pipeline depth.
- Source changes happen glitch-free: a change is committed only at a frame boundary, then the output is blanked for a programmable number of frames.
- An audio mute flag is driven during every transition. The block sits between the video generators and the HDMI transmitter, all in one pixel clock domain.

Parameters:
- NUM_SRC, 4, number of video sources (2..8)
- SEL_W, 3, width of sel; must satisfy 2**SEL_W >= NUM_SRC
- COLOR_W, 8, bits per colour component
- PIPE_DEPTH, 2, output register stages (>=1)
- BLANK_FRAMES, 2, frames blanked after a switch (>=1)
- VS_POL, 1, vsync active level (1 = active high)
- TIMEOUT_CYC, 2000000, max cycles to wait for the old source's vsync
- TO_W, 21, timeout counter width

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- sel  in  SEL_W  requested source index
- src_rgb  in  NUM_SRC*3*COLOR_W  packed RGB; source k occupies slice k, R in the MSBs
- src_hs  in  NUM_SRC  hsync per source
- src_vs  in  NUM_SRC  vsync per source
- src_de  in  NUM_SRC  data enable per source
- out_rgb  out  3*COLOR_W  selected RGB, forced to 0 when out_de=0
- out_hs  out  1  selected hsync
- out_vs  out  1  selected vsync
- out_de  out  1  selected DE, forced to 0 while blanking
- active_src  out  SEL_W  index currently routed to the output
- switching  out  1  high in WAIT_VS and MUTE
- audio_mute  out  1  high in WAIT_VS and MUTE

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=MUTE, cur=0, tgt=0, frame_cnt=0, to_cnt=0, all pipeline stages cleared.
  - Outputs: out_rgb=0, out_de=0, out_hs=0, out_vs=~VS_POL, active_src=0, switching=1, audio_mute=1.
- Mux: stage 0 takes the source cur. out_* are stage 0 delayed by PIPE_DEPTH-1 further registers, so input-to-output latency is PIPE_DEPTH cycles. All outputs, including the flags, are aligned through the same pipeline.
- vs_lead: one-cycle pulse on the leading (inactive-to-active) edge of src_vs[cur], detected pre-pipeline with a 1-cycle history register. The history register reloads on every cur change, so no false edge is detected.
- States:
  - LOCKED:
    - If sel != cur and sel < NUM_SRC: tgt<=sel, to_cnt<=0, go to WAIT_VS.
    - If sel >= NUM_SRC: ignored; stay.
  - WAIT_VS:
    - Output is still routed from cur, unblanked; audio_mute=1.
    - If sel changes to a valid index, tgt<=sel. If sel returns to cur, go to LOCKED with no blanking.
    - On vs_lead, or when to_cnt reaches TIMEOUT_CYC-1: cur<=tgt, frame_cnt<=0, go to MUTE.
  - MUTE:
    - de and rgb are forced to 0; hs/vs pass through from cur.
    - Each vs_lead increments frame_cnt. When frame_cnt reaches BLANK_FRAMES, go to LOCKED.
    - If sel changes to a valid index != cur: go to WAIT_VS with tgt<=sel. The timeout applies again.
    - MUTE has no timeout; a dead source keeps the output blanked indefinitely.
- Blank decision: made at stage 0 from the state, so the forced-blank window aligns with the frame boundary at the output.
- Simultaneous events:
  - sel change in the same cycle as vs_lead in WAIT_VS: the new sel wins as tgt, and the switch commits in that cycle.
  - vs_lead in the same cycle as to_cnt expiry: a single commit.
- Widths: to_cnt saturates at TIMEOUT_CYC-1 and must not wrap. frame_cnt is sized clog2(BLANK_FRAMES+1).
- active_src updates at the output PIPE_DEPTH cycles after cur changes.

Test Plan:
- Reset release, src0 vsync every 1000 cycles:
  - Output blanked for 2 frames; locks at the 2nd vs_lead.
  - audio_mute falls PIPE_DEPTH=2 cycles after the lock.
  - out_rgb then equals src0 RGB delayed 2 cycles.
- sel 0->2 mid-frame:
  - Output stays on src0 until the src0 vs leading edge.
  - Then active_src=2 with de=0 for 2 src2 frames, then live src2 data.
  - No out_de pulse shorter than a source line.
- sel 0->1 then back to 0 before src0 vsync: returns to LOCKED; out_de never forced low; audio_mute pulse only.
- sel=5 with NUM_SRC=4: ignored; active_src stays 0, switching=0.
- src0 vsync held inactive, sel 0->3, TIMEOUT_CYC=50: commit at cycle 50 after the request, then MUTE on src3.
- reset_n asserted mid-MUTE: outputs go to their reset values immediately (asynchronously); the sequence restarts on src0.
